// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift sequencer.
//   state_e    : sequencer states (IDLE, SHIFT, DONE)
//   op_e       : shift operation (sll, srl, sra, pass-through)
//   SHAMT_W    : width of a shift amount
//   decode_op  : priority decode of the op-select inputs (sll > srl > sra)
package shift_pkg;

  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL  = 2'd0,
    OP_SRL  = 2'd1,
    OP_SRA  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  function automatic op_e decode_op(input logic is_sll, input logic is_srl,
                                    input logic is_sra);
    if (is_sll)      return OP_SLL;
    else if (is_srl) return OP_SRL;
    else if (is_sra) return OP_SRA;
    else             return OP_PASS;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational partial shifter: shifts data_i by k_i bits (0..STEP) for one
// sequencer cycle.
//   data_i : value to shift
//   k_i    : shift distance for this cycle
//   op_i   : operation; OP_PASS returns data_i unchanged
//   fill_i : sign bit inserted from the left for OP_SRA
//   data_o : shifted value
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] k_i,
  input  op_e                op_i,
  input  logic               fill_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    case (op_i)
      OP_SLL:  data_o = data_i << k_i;
      OP_SRL:  data_o = data_i >> k_i;
      // Logical shift, then set the vacated top k bits to the fill bit.
      OP_SRA:  data_o = (data_i >> k_i) |
                        (~({WIDTH{1'b1}} >> k_i) & {WIDTH{fill_i}});
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer for the EX stage. Latches operands on start and
// shifts STEP bits per cycle until the requested amount is consumed.
//   clk, reset        : clock, synchronous active-high reset
//   start             : request an op (ignored while busy)
//   flush             : abort; in-flight result discarded, shiftout held
//   rd1               : bits [4:0] give the amount when v=1
//   rd2               : operand being shifted
//   shamt             : amount when v=0
//   issll/issrl/issra : op select, priority sll > srl > sra, none = pass
//   busy              : high while shifting
//   done              : one-cycle pulse when shiftout is updated
//   shiftout          : last completed result
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned STEP  = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   rd1,
  input  logic [WIDTH-1:0]   rd2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               issll,
  input  logic               issrl,
  input  logic               issra,
  input  logic               v,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   shiftout
);

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_e               state_q, state_d;
  op_e                  op_q, op_d, op_in;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     shiftout_q, shiftout_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 fill_q, fill_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SHAMT_W-1:0]   amt_in, step_k;
  logic [WIDTH-1:0]     step_out;
  logic                 final_step;
  logic                 unused_rd1_hi;

  assign unused_rd1_hi = ^rd1[WIDTH-1:SHAMT_W];

  assign op_in      = decode_op(issll, issrl, issra);
  assign amt_in     = (op_in == OP_PASS) ? '0 : (v ? rd1[SHAMT_W-1:0] : shamt);
  assign final_step = (cnt_q <= STEP_AMT);
  assign step_k     = final_step ? cnt_q : STEP_AMT;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (work_q),
    .k_i    (step_k),
    .op_i   (op_q),
    .fill_i (fill_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    shiftout_d = shiftout_q;
    done_d     = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_SHIFT: begin
          work_d = step_out;
          if (final_step) begin
            cnt_d      = '0;
            shiftout_d = step_out;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else begin
            cnt_d = cnt_q - STEP_AMT;
          end
        end
        default: begin
          // IDLE and DONE accept a new op identically (back-to-back issue).
          state_d = S_IDLE;
          if (start) begin
            work_d = rd2;
            op_d   = op_in;
            fill_d = rd2[WIDTH-1];
            cnt_d  = amt_in;
            if (amt_in == '0) begin
              shiftout_d = rd2;
              done_d     = 1'b1;
              state_d    = S_DONE;
            end else begin
              state_d = S_SHIFT;
            end
          end
        end
      endcase
    end

    busy_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_PASS;
      work_q     <= '0;
      cnt_q      <= '0;
      fill_q     <= 1'b0;
      shiftout_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      shiftout_q <= shiftout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign shiftout = shiftout_q;

endmodule
